rx_ber_checker: RTL
===================

// Module: rx_ber_checker
// PURPOSE
// Receive-side stage placed directly after the BPSK polyphase TX filter (12-bit signed samples, USAMPLE per symbol).
// - Decimates the filtered stream at a selectable phase and slices each symbol by its sign.
// - Searches the delay against the transmitted-symbol reference and locks onto the best one.
// - Then counts bits and bit errors for BER measurement; drops lock and re-searches on error bursts.
// PARAMETERS
// NBIT_IN     12    sample width, signed, integer format
// USAMPLE     4     samples per symbol (power of 2)
// MAX_LAT     32    candidate reference delays searched, 0..MAX_LAT-1 (power of 2)
// SEARCH_LEN  128   symbols per search/monitor window (power of 2)
// LOSS_THR    16    window errors above this value while locked -> lose lock
// CNT_BITS    32    width of bit/error counters
// PORTS
// clk          in   1           system clock
// rst          in   1           asynchronous reset, active low
// enable       in   1           same enable that drives the TX filter
// clear        in   1           sync pulse: zero bit_count/err_count, state kept
// phase_sel    in   log2(US)    decimation phase, 0..USAMPLE-1
// sample_in    in   NBIT_IN     signed filtered sample, one per clk
// ref_bit      in   1           transmitted symbol (same signal that feeds the TX filter)
// rx_bit       out  1           sliced symbol
// rx_valid     out  1           1-clk pulse, rx_bit valid
// locked       out  1           delay found, BER counting active
// latency_out  out  log2(MAX_LAT)  locked delay, in symbols
// bit_count    out  CNT_BITS    bits compared while locked (saturating)
// err_count    out  CNT_BITS    errors while locked (saturating)
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0; phase, delay line, state=IDLE, best_err=all ones.
// - Phase counter: enable rising (enable_q=0, enable=1) -> phase<=0; otherwise, while enable_q, phase<=phase+1 mod USAMPLE.
// - strobe = enable & (phase==phase_sel).
// - Slice: sym = sample_in[NBIT_IN-1] (negative->1, zero/positive->0); TX maps 1 to negative.
// - On strobe: rx_bit<=sym; rx_valid<=1 (latency 1 clk); ref_sr<={ref_sr[MAX_LAT-2:0],ref_bit}.
//   ref_sr[L] = ref_bit captured L+1 strobes earlier.
// - err(L) = sym ^ ref_sr[L], evaluated against pre-shift ref_sr.
// - FSM:
//   IDLE: enable=1 -> SEARCH (cand=0, win_cnt=0, win_err=0, best_err=all ones).
//   SEARCH: on strobe win_err+=err(cand), win_cnt++.
//     At win_cnt==SEARCH_LEN: if win_err<best_err (strict; ties keep lower delay) -> best_err/best_lat update; cand++, window cleared.
//     After cand==MAX_LAT-1 closes: latency_out<=best_lat, locked<=1, counters<=0 -> LOCKED.
//   LOCKED: on strobe bit_count++ and err_count+=err(latency_out), both saturating at all ones.
//     Window counter runs as in SEARCH; at window end, if win_err>LOSS_THR -> SEARCH, locked<=0, counters hold.
//   Any state: enable=0 -> IDLE next clk; locked<=0; counters/latency_out hold.
// - clear: bit_count/err_count<=0 that clk; clear wins over a simultaneous increment.
// - Search time: MAX_LAT*SEARCH_LEN strobes (4096 with defaults), plus 1 clk to assert locked.
// STRUCTURE
// - Shared package: USAMPLE, NBIT_IN, phase width, state encoding (IDLE/SEARCH/LOCKED).
//   USAMPLE and NBIT_IN are also used by the TX filter.
// - Sub-module rx_decimator: phase counter, enable edge detect, slicer, rx_bit/rx_valid.
// - Top: delay line, window counters, FSM, BER counters.
// TESTING
// 1. TX filter -> this block, PRBS9 ref, phase_sel=0 -> locked at 4096 strobes+1clk; latency_out = TX delay; err_count=0 after 10000 bits.
// 2. sample_in=+256/-256 from ref delayed 6 strobes -> latency_out=5; bit_count=err_count+correct; err_count=0.
// 3. Locked, invert 1 of every 100 symbols -> err_count = 100 after 10000 bits; locked stays 1.
// 4. Locked, 128 symbols random sign -> window errors >16 -> locked=0; ref restored -> relock to same latency.
// 5. rst low mid-SEARCH -> all outputs 0 immediately; enable low mid-LOCKED -> IDLE, counters hold; enable high -> search from cand 0.
// 6. clear pulse coincident with an error strobe -> both counters 0 next clk; counting resumes next strobe.

Source files
------------

// File: rtl/rx_ber_checker_pkg.sv
// Shared definitions for the BPSK receive-side BER checker; USAMPLE and NBIT_IN
// are also used by the TX polyphase filter.
package rx_ber_checker_pkg;
    localparam int NBIT_IN = 12;
    localparam int USAMPLE = 4;
    localparam int PHASE_W = $clog2(USAMPLE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef logic signed [NBIT_IN-1:0] sample_t;
endpackage

// File: rtl/rx_ber_checker_if.sv
// Stream and status bundle between the filtered-sample source and the BER checker.
interface rx_ber_checker_if
    import rx_ber_checker_pkg::*;
#(
    parameter int MAX_LAT  = 32,
    parameter int CNT_BITS = 32
);
    localparam int LAT_W = $clog2(MAX_LAT);

    logic                enable;
    logic                clear;
    logic [PHASE_W-1:0]  phase_sel;
    sample_t             sample_in;
    logic                ref_bit;
    logic                rx_bit;
    logic                rx_valid;
    logic                locked;
    logic [LAT_W-1:0]    latency_out;
    logic [CNT_BITS-1:0] bit_count;
    logic [CNT_BITS-1:0] err_count;

    modport master (
        output enable, clear, phase_sel, sample_in, ref_bit,
        input  rx_bit, rx_valid, locked, latency_out, bit_count, err_count
    );

    modport slave (
        input  enable, clear, phase_sel, sample_in, ref_bit,
        output rx_bit, rx_valid, locked, latency_out, bit_count, err_count
    );
endinterface

// File: rtl/rx_ber_checker_decimator.sv
// Symbol-rate decimator: phase counter restarted on enable rising, sign slicer,
// registered rx_bit/rx_valid one clock after the strobe.
module rx_decimator
    import rx_ber_checker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] phase_sel,
    input  sample_t            sample_in,
    output logic               strobe,
    output logic               sym,
    output logic               rx_bit,
    output logic               rx_valid
);
    logic               enable_q;
    logic [PHASE_W-1:0] phase;

    assign strobe = enable & (phase == phase_sel);
    // TX maps symbol 1 to a negative level; zero slices as 0
    assign sym    = (sample_in < 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q <= 1'b0;
            phase    <= '0;
            rx_bit   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q)
                phase <= '0;
            else if (enable_q)
                phase <= phase + 1'b1;
            rx_valid <= strobe;
            if (strobe)
                rx_bit <= sym;
        end
    end
endmodule

// File: rtl/rx_ber_checker.sv
// BER checker: searches the reference delay with the lowest window error count,
// locks onto it, then counts bits/errors until an error burst forces a re-search.
module rx_ber_checker
    import rx_ber_checker_pkg::*;
#(
    parameter int MAX_LAT    = 32,
    parameter int SEARCH_LEN = 128,
    parameter int LOSS_THR   = 16,
    parameter int CNT_BITS   = 32
)
(
    input  logic             clk,
    input  logic             rst,
    rx_ber_checker_if.slave  bus
);
    localparam int LAT_W = $clog2(MAX_LAT);
    localparam int WIN_W = $clog2(SEARCH_LEN);
    localparam int ERR_W = WIN_W + 1;

    logic                vld_p0, sym_p0, rx_bit_p1, vld_p1;
    logic [1:0]          state;
    logic [MAX_LAT-1:0]  ref_sr;
    logic [LAT_W-1:0]    cand, best_lat, latency, lat_sel;
    logic [WIN_W-1:0]    win_cnt;
    logic [ERR_W-1:0]    win_err, best_err, win_err_nxt;
    logic                locked, err_p0, win_end, better;
    logic [CNT_BITS-1:0] bit_cnt, err_cnt;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_BITS'(1) : v;
    endfunction

    rx_decimator u_decim (
        .clk       (clk),
        .rst       (rst),
        .enable    (bus.enable),
        .phase_sel (bus.phase_sel),
        .sample_in (bus.sample_in),
        .strobe    (vld_p0),
        .sym       (sym_p0),
        .rx_bit    (rx_bit_p1),
        .rx_valid  (vld_p1)
    );

    // Error is taken against the delay line before this strobe's shift
    assign lat_sel     = (state == ST_LOCKED) ? latency : cand;
    assign err_p0      = sym_p0 ^ ref_sr[lat_sel];
    assign win_err_nxt = win_err + ERR_W'(err_p0);
    assign win_end     = (win_cnt == WIN_W'(SEARCH_LEN - 1));
    assign better      = (win_err_nxt < best_err);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ref_sr   <= '0;
            cand     <= '0;
            best_lat <= '0;
            latency  <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            best_err <= '1;
            locked   <= 1'b0;
            bit_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (vld_p0)
                ref_sr <= {ref_sr[MAX_LAT-2:0], bus.ref_bit};

            if (!bus.enable) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_SEARCH;
                        cand     <= '0;
                        win_cnt  <= '0;
                        win_err  <= '0;
                        best_err <= '1;
                    end
                    ST_SEARCH: if (vld_p0) begin
                        if (win_end) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            if (better) begin
                                best_err <= win_err_nxt;
                                best_lat <= cand;
                            end
                            if (cand == LAT_W'(MAX_LAT - 1)) begin
                                latency <= better ? cand : best_lat;
                                locked  <= 1'b1;
                                bit_cnt <= '0;
                                err_cnt <= '0;
                                state   <= ST_LOCKED;
                            end else begin
                                cand <= cand + 1'b1;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_nxt;
                        end
                    end
                    ST_LOCKED: if (vld_p0) begin
                        bit_cnt <= sat_inc(bit_cnt, 1'b1);
                        err_cnt <= sat_inc(err_cnt, err_p0);
                        if (win_end) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            if (win_err_nxt > ERR_W'(LOSS_THR)) begin
                                state    <= ST_SEARCH;
                                locked   <= 1'b0;
                                cand     <= '0;
                                best_err <= '1;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_nxt;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            // Clear overrides any increment on the same clock
            if (bus.clear) begin
                bit_cnt <= '0;
                err_cnt <= '0;
            end
        end
    end

    assign bus.rx_bit      = rx_bit_p1;
    assign bus.rx_valid    = vld_p1;
    assign bus.locked      = locked;
    assign bus.latency_out = latency;
    assign bus.bit_count   = bit_cnt;
    assign bus.err_count   = err_cnt;
endmodule
